vec_reg_file_lanes: RTL and testbench
=====================================

// Module: vec_reg_file_lanes
// PURPOSE
//  Parametrised vector register file: NUM_REGS x (NUM_LANES*LANE_W), two async read ports, one full-vector write port with per-lane mask.
//  Adds a lane-serial load sequencer that fills one register from a memory beat stream (one lane per beat) with valid/ready handshake.
//  Per-register busy tracking for the register under load. Optional write-to-read bypass.
//  Sits between the execute stage (wr_*/rd_*) and the memory load path (ld_*).
// PARAMETERS
//  NUM_REGS   16  number of vector registers; ADDR_W = $clog2(NUM_REGS)
//  LANE_W     32  bits per lane
//  NUM_LANES  4   lanes per register; VEC_W = NUM_LANES*LANE_W, CNT_W = $clog2(NUM_LANES)
//  BYPASS     1   1: same-cycle accepted writes are forwarded to read data; 0: reads show stored contents only
// PORTS
//  clk            in   1          rising-edge clock
//  reset          in   1          synchronous, active-high
//  wr_en          in   1          result write request
//  wr_addr        in   ADDR_W     result destination register
//  wr_lane_mask   in   NUM_LANES  bit i=1 writes lane i (bits [i*LANE_W +: LANE_W])
//  wr_data        in   VEC_W      result data
//  wr_conflict    out  1          registered pulse: previous-cycle write dropped (target busy)
//  ld_start       in   1          begin lane-serial load into ld_addr
//  ld_addr        in   ADDR_W     load destination register
//  ld_ready       out  1          sequencer idle, ld_start accepted
//  ld_abort       in   1          terminate load in progress
//  ld_beat_valid  in   1          memory beat present
//  ld_beat_data   in   LANE_W     memory beat payload
//  ld_beat_ready  out  1          sequencer accepts beat
//  ld_done        out  1          registered pulse: load completed
//  rd_addr1/2     in   ADDR_W     read addresses
//  rd_data1/2     out  VEC_W      read data (combinational)
//  rd_busy1/2     out  1          addressed register is under load
// BEHAVIOUR
//  Reset (sync): all registers 0, FSM IDLE, lane counter 0, busy clear; ld_done=0, wr_conflict=0, ld_ready=1, ld_beat_ready=0.
//  FSM IDLE: ld_ready=1, ld_beat_ready=0. ld_start -> capture ld_addr, cnt=0, set busy, -> LOAD.
//  FSM LOAD: ld_ready=0, ld_beat_ready=1. Beat accepted when valid&ready: lane[cnt] of target <= ld_beat_data.
//   cnt < NUM_LANES-1: cnt++. cnt == NUM_LANES-1: clear busy, -> IDLE, ld_done=1 next cycle (register then holds full vector).
//   ld_abort (priority over beat): -> IDLE, busy cleared, beat in that cycle NOT written, lanes already written retained, no ld_done.
//  ld_start in LOAD ignored. ld_start allowed in cycle ld_done=1 (FSM already IDLE). ld_abort in IDLE ignored.
//  Write port: wr_en & target not busy -> masked lanes written at next edge; mask 0 is a legal no-op.
//   wr_en to busy register -> whole write dropped, wr_conflict=1 next cycle. Busy checked on registered busy state (start cycle: not yet busy, write accepted).
//  Write and ld_start same addr, same cycle: write accepted; subsequent beats overwrite lanes.
//  Reads: rd_dataN = stored register. BYPASS=1: accepted wr lanes to rd_addrN replace those lanes; accepted beat to rd_addrN replaces lane cnt.
//  rd_busyN = busy & (rd_addrN == load target). Both read ports independent; same address on both legal.
//  Reset mid-load: load discarded, all state per reset values, no ld_done.
//  Lane index i maps to bits [i*LANE_W +: LANE_W]; lane 0 is loaded first.
// STRUCTURE
//  Package vrf_pkg: state enum {VRF_IDLE, VRF_LOAD}, default parameter constants, lane slice helper function.
//  Sub-module vrf_load_seq: FSM, lane counter, target/busy register, ld_* handshake; outputs beat write strobe, lane index, target.
//  Top: storage array, write merge (result vs beat strobes), conflict check, bypass muxes.
// TESTING
//  Defaults: wr_en addr 3 mask 4'b0101 data {32'hD,32'hC,32'hB,32'hA} -> rd_data1(3)=={0,32'hC,0,32'hA}; same cycle with BYPASS=1 shows same value.
//  ld_start addr 5, beats 11,22,33,44 back-to-back -> rd_data(5)=={44,33,22,11}; ld_done pulses 1 cycle after beat 44; rd_busy(5)=1 during LOAD only.
//  Load addr 2 with valid gaps (beat every 3rd cycle) -> 4 beats captured in order, ld_beat_ready high throughout LOAD, no extra writes.
//  During load addr 7, wr_en addr 7 mask 4'hF -> wr_conflict=1 next cycle, reg 7 ends with only beat data; wr_en addr 8 same cycle succeeds.
//  Abort after 2 beats into reg 9 (prior 0) -> lanes 0,1 hold beats, lanes 2,3 = 0, no ld_done, ld_ready=1 next cycle.
//  reset asserted after beat 1 of a load -> all regs 0, ld_ready=1, ld_done never asserts; new ld_start accepted afterwards.

Source files
------------

// File: rtl/vrf_pkg.sv
// Shared constants and helpers for the lane-organised vector register file.
package vrf_pkg;

  localparam int unsigned VRF_NUM_REGS  = 16;
  localparam int unsigned VRF_LANE_W    = 32;
  localparam int unsigned VRF_NUM_LANES = 4;

  typedef logic [0:0] vrf_state_t;
  localparam vrf_state_t VRF_IDLE = 1'b0;
  localparam vrf_state_t VRF_LOAD = 1'b1;

  // Low bit position of a lane inside a packed vector.
  function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned lane_w);
    return lane * lane_w;
  endfunction

endpackage

// File: rtl/vrf_load_seq.sv
// Lane-serial load sequencer: owns the load target, lane counter and busy flag.
module vrf_load_seq
  import vrf_pkg::*;
#(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned CNT_W     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic              ld_abort,
  input  logic              ld_beat_valid,
  output logic              idle_c,
  output logic              beat_ready_c,
  output logic              beat_we_c,
  output logic              ld_done,
  output logic              busy,
  output logic [ADDR_W-1:0] target,
  output logic [CNT_W-1:0]  lane
);

  vrf_state_t        state, state_n;
  logic [CNT_W-1:0]  cnt_n;
  logic [ADDR_W-1:0] target_n;
  logic              busy_n;
  logic              done_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= VRF_IDLE;
      lane    <= '0;
      target  <= '0;
      busy    <= 1'b0;
      ld_done <= 1'b0;
    end else begin
      state   <= state_n;
      lane    <= cnt_n;
      target  <= target_n;
      busy    <= busy_n;
      ld_done <= done_n;
    end
  end

  // Abort wins over a beat presented in the same cycle.
  always_comb begin
    state_n   = state;
    cnt_n     = lane;
    target_n  = target;
    busy_n    = busy;
    done_n    = 1'b0;
    beat_we_c = 1'b0;
    case (state)
      VRF_IDLE: begin
        if (ld_start) begin
          target_n = ld_addr;
          cnt_n    = '0;
          busy_n   = 1'b1;
          state_n  = VRF_LOAD;
        end
      end
      VRF_LOAD: begin
        if (ld_abort) begin
          busy_n  = 1'b0;
          cnt_n   = '0;
          state_n = VRF_IDLE;
        end else if (ld_beat_valid) begin
          beat_we_c = 1'b1;
          if (lane == CNT_W'(NUM_LANES - 1)) begin
            busy_n  = 1'b0;
            done_n  = 1'b1;
            cnt_n   = '0;
            state_n = VRF_IDLE;
          end else begin
            cnt_n = lane + CNT_W'(1);
          end
        end
      end
      default: state_n = VRF_IDLE;
    endcase
  end

  assign idle_c       = (state == VRF_IDLE);
  assign beat_ready_c = (state == VRF_LOAD);

endmodule

// File: rtl/vec_reg_file_lanes.sv
// Vector register file with masked result writes, lane-serial loads and optional bypass.
module vec_reg_file_lanes
  import vrf_pkg::*;
#(
  parameter int unsigned NUM_REGS  = VRF_NUM_REGS,
  parameter int unsigned LANE_W    = VRF_LANE_W,
  parameter int unsigned NUM_LANES = VRF_NUM_LANES,
  parameter bit          BYPASS    = 1'b1,
  localparam int unsigned ADDR_W   = $clog2(NUM_REGS),
  localparam int unsigned VEC_W    = NUM_LANES * LANE_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [NUM_LANES-1:0] wr_lane_mask,
  input  logic [VEC_W-1:0]     wr_data,
  output logic                 wr_conflict,
  input  logic                 ld_start,
  input  logic [ADDR_W-1:0]    ld_addr,
  output logic                 ld_ready,
  input  logic                 ld_abort,
  input  logic                 ld_beat_valid,
  input  logic [LANE_W-1:0]    ld_beat_data,
  output logic                 ld_beat_ready,
  output logic                 ld_done,
  input  logic [ADDR_W-1:0]    rd_addr1,
  input  logic [ADDR_W-1:0]    rd_addr2,
  output logic [VEC_W-1:0]     rd_data1,
  output logic [VEC_W-1:0]     rd_data2,
  output logic                 rd_busy1,
  output logic                 rd_busy2
);

  localparam int unsigned CNT_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic [VEC_W-1:0]  regs [NUM_REGS];
  logic              beat_we_c;
  logic              busy;
  logic [ADDR_W-1:0] target;
  logic [CNT_W-1:0]  lane;
  logic              wr_hit_busy_c;
  logic              wr_ok_c;
  logic [VEC_W-1:0]  wr_bits_c;
  logic [VEC_W-1:0]  beat_bits_c;
  logic [VEC_W-1:0]  beat_vec_c;

  vrf_load_seq #(
    .ADDR_W    (ADDR_W),
    .NUM_LANES (NUM_LANES),
    .CNT_W     (CNT_W)
  ) u_seq (
    .clk           (clk),
    .reset         (reset),
    .ld_start      (ld_start),
    .ld_addr       (ld_addr),
    .ld_abort      (ld_abort),
    .ld_beat_valid (ld_beat_valid),
    .idle_c        (ld_ready),
    .beat_ready_c  (ld_beat_ready),
    .beat_we_c     (beat_we_c),
    .ld_done       (ld_done),
    .busy          (busy),
    .target        (target),
    .lane          (lane)
  );

  // Busy is judged on the registered flag, so a write in the start cycle still lands.
  assign wr_hit_busy_c = busy && (wr_addr == target);
  assign wr_ok_c       = wr_en && !wr_hit_busy_c;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_mask
    assign wr_bits_c[i*LANE_W +: LANE_W] = {LANE_W{wr_lane_mask[i]}};
  end

  assign beat_bits_c = VEC_W'({LANE_W{1'b1}}) << lane_lo(32'(lane), LANE_W);
  assign beat_vec_c  = VEC_W'(ld_beat_data) << lane_lo(32'(lane), LANE_W);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      wr_conflict <= 1'b0;
    end else begin
      if (wr_ok_c) regs[wr_addr] <= (regs[wr_addr] & ~wr_bits_c) | (wr_data & wr_bits_c);
      if (beat_we_c) regs[target] <= (regs[target] & ~beat_bits_c) | (beat_vec_c & beat_bits_c);
      wr_conflict <= wr_en && wr_hit_busy_c;
    end
  end

  logic [ADDR_W-1:0] rd_addr_c [2];
  logic [VEC_W-1:0]  rd_mux_c  [2];

  assign rd_addr_c[0] = rd_addr1;
  assign rd_addr_c[1] = rd_addr2;

  // A write and a beat never target the same register in one cycle, so order is free.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_mux_c[p] = regs[rd_addr_c[p]];
      if (BYPASS) begin
        if (wr_ok_c && (wr_addr == rd_addr_c[p]))
          rd_mux_c[p] = (rd_mux_c[p] & ~wr_bits_c) | (wr_data & wr_bits_c);
        if (beat_we_c && (target == rd_addr_c[p]))
          rd_mux_c[p] = (rd_mux_c[p] & ~beat_bits_c) | (beat_vec_c & beat_bits_c);
      end
    end
  end

  assign rd_data1 = rd_mux_c[0];
  assign rd_data2 = rd_mux_c[1];
  assign rd_busy1 = busy && (rd_addr1 == target);
  assign rd_busy2 = busy && (rd_addr2 == target);

endmodule

// File: tb/tb_vec_reg_file_lanes.sv
// Scoreboard bench for vec_reg_file_lanes: a reference register model feeds expectations into a queue.
module tb_vec_reg_file_lanes;

  logic         clk = 1'b0;
  logic         reset;
  logic         wr_en;
  logic [3:0]   wr_addr;
  logic [3:0]   wr_lane_mask;
  logic [127:0] wr_data;
  logic         wr_conflict;
  logic         ld_start;
  logic [3:0]   ld_addr;
  logic         ld_ready;
  logic         ld_abort;
  logic         ld_beat_valid;
  logic [31:0]  ld_beat_data;
  logic         ld_beat_ready;
  logic         ld_done;
  logic [3:0]   rd_addr1, rd_addr2;
  logic [127:0] rd_data1, rd_data2;
  logic         rd_busy1, rd_busy2;

  vec_reg_file_lanes dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_lane_mask(wr_lane_mask), .wr_data(wr_data),
    .wr_conflict(wr_conflict),
    .ld_start(ld_start), .ld_addr(ld_addr), .ld_ready(ld_ready), .ld_abort(ld_abort),
    .ld_beat_valid(ld_beat_valid), .ld_beat_data(ld_beat_data), .ld_beat_ready(ld_beat_ready),
    .ld_done(ld_done),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .rd_busy1(rd_busy1), .rd_busy2(rd_busy2)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    logic [127:0] exp;
  } exp_t;

  exp_t         sb[$];
  logic [127:0] model [16];
  int           n_chk  = 0;
  int           n_pass = 0;
  logic [3:0]   tgt;
  int           lane_m;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic expect_val(input string tag, input logic [127:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic observe(input logic [127:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 128'd1, 128'd0);
    end else begin
      e = sb.pop_front();
      chk(e.tag, obs, e.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic m_write(input int a, input logic [3:0] mask, input logic [127:0] d);
    for (int l = 0; l < 4; l++)
      if (mask[l]) model[a][l*32 +: 32] = d[l*32 +: 32];
  endtask

  task automatic start_load(input logic [3:0] a);
    ld_start = 1'b1;
    ld_addr  = a;
    tgt      = a;
    lane_m   = 0;
    step();
    ld_start = 1'b0;
  endtask

  task automatic beat(input logic [31:0] v);
    ld_beat_valid = 1'b1;
    ld_beat_data  = v;
    model[tgt][lane_m*32 +: 32] = v;
    lane_m++;
    step();
    ld_beat_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    for (int r = 0; r < 16; r++) model[r] = '0;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_lane_mask = '0; wr_data = '0;
    ld_start = 1'b0; ld_addr = '0; ld_abort = 1'b0; ld_beat_valid = 1'b0; ld_beat_data = '0;
    rd_addr1 = 4'd15; rd_addr2 = 4'd0;
    repeat (2) step();

    expect_val("rst_ld_ready", 1);   observe(ld_ready);
    expect_val("rst_beat_ready", 0); observe(ld_beat_ready);
    expect_val("rst_ld_done", 0);    observe(ld_done);
    expect_val("rst_conflict", 0);   observe(wr_conflict);
    expect_val("rst_rd_data", 0);    observe(rd_data1);
    reset = 1'b0;

    // masked write with same-cycle bypass
    wr_en = 1'b1; wr_addr = 4'd3; wr_lane_mask = 4'b0101;
    wr_data = {32'hD, 32'hC, 32'hB, 32'hA};
    m_write(3, 4'b0101, wr_data);
    rd_addr1 = 4'd3; rd_addr2 = 4'd3;
    #1;
    expect_val("wr_bypass_lit", {32'h0, 32'hC, 32'h0, 32'hA}); observe(rd_data1);
    expect_val("wr_bypass_p2", model[3]);                      observe(rd_data2);
    step();
    wr_en = 1'b0;
    #1;
    expect_val("wr_stored", model[3]); observe(rd_data1);

    wr_en = 1'b1; wr_lane_mask = 4'b0000; wr_data = '1;
    step();
    wr_en = 1'b0;
    expect_val("wr_mask0_noop", model[3]); observe(rd_data1);

    // back-to-back load into reg 5
    start_load(4'd5);
    rd_addr1 = 4'd5; rd_addr2 = 4'd3;
    #1;
    expect_val("ld5_ready_low", 0); observe(ld_ready);
    expect_val("ld5_beat_ready", 1); observe(ld_beat_ready);
    expect_val("ld5_busy1", 1);      observe(rd_busy1);
    expect_val("ld5_busy2_other", 0); observe(rd_busy2);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        ld_beat_valid = 1'b1; ld_beat_data = 32'd22;
        #1;
        expect_val("ld5_beat_bypass", {64'd0, 32'd22, 32'd11}); observe(rd_data1);
      end
      beat(32'((i + 1) * 11));
      if (i < 3) begin
        expect_val("ld5_no_early_done", 0); observe(ld_done);
      end
    end
    expect_val("ld5_done", 1);     observe(ld_done);
    expect_val("ld5_busy_clr", 0); observe(rd_busy1);
    expect_val("ld5_data", {32'd44, 32'd33, 32'd22, 32'd11}); observe(rd_data1);

    // start accepted in the ld_done cycle; load reg 2 with gapped beats
    start_load(4'd2);
    expect_val("ld5_done_pulse", 0); observe(ld_done);
    expect_val("ld2_accepted", 0);   observe(ld_ready);
    rd_addr1 = 4'd2;
    for (int i = 0; i < 4; i++) begin
      repeat (2) step();
      expect_val("ld2_gap_ready", 1); observe(ld_beat_ready);
      v = $urandom;
      beat(v);
    end
    expect_val("ld2_done", 1);    observe(ld_done);
    expect_val("ld2_data", model[2]); observe(rd_data1);
    step();

    // write conflict on reg 7 while loading; write to reg 8 proceeds; ld_start in LOAD ignored
    start_load(4'd7);
    wr_en = 1'b1; wr_addr = 4'd7; wr_lane_mask = 4'hF; wr_data = {4{32'hBAD0BAD0}};
    ld_start = 1'b1; ld_addr = 4'd10;
    beat(32'h7000_0001);
    ld_start = 1'b0;
    expect_val("wr7_conflict", 1); observe(wr_conflict);
    wr_addr = 4'd8; wr_data = {32'h8888_0004, 32'h8888_0003, 32'h8888_0002, 32'h8888_0001};
    m_write(8, 4'hF, wr_data);
    beat(32'h7000_0002);
    wr_en = 1'b0;
    expect_val("wr8_no_conflict", 0); observe(wr_conflict);
    rd_addr2 = 4'd10;
    #1;
    expect_val("ld10_ignored_busy", 0); observe(rd_busy2);
    beat(32'h7000_0003);
    beat(32'h7000_0004);
    expect_val("ld7_done", 1); observe(ld_done);
    rd_addr1 = 4'd7; rd_addr2 = 4'd8;
    #1;
    expect_val("ld7_data", model[7]); observe(rd_data1);
    expect_val("wr8_data", model[8]); observe(rd_data2);

    // abort in IDLE is ignored, abort in LOAD keeps earlier lanes
    ld_abort = 1'b1;
    step();
    ld_abort = 1'b0;
    expect_val("abort_idle_ready", 1); observe(ld_ready);
    start_load(4'd9);
    beat(32'h9000_0001);
    beat(32'h9000_0002);
    ld_abort = 1'b1; ld_beat_valid = 1'b1; ld_beat_data = 32'hDEAD_BEEF;
    step();
    ld_abort = 1'b0; ld_beat_valid = 1'b0;
    rd_addr1 = 4'd9;
    #1;
    expect_val("abort_ready", 1);   observe(ld_ready);
    expect_val("abort_no_done", 0); observe(ld_done);
    expect_val("abort_busy", 0);    observe(rd_busy1);
    expect_val("abort_data", {64'd0, 32'h9000_0002, 32'h9000_0001}); observe(rd_data1);

    // reset in the middle of a load
    start_load(4'd12);
    beat(32'hC000_0001);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int r = 0; r < 16; r++) model[r] = '0;
    rd_addr1 = 4'd12; rd_addr2 = 4'd3;
    #1;
    expect_val("mrst_ready", 1);   observe(ld_ready);
    expect_val("mrst_no_done", 0); observe(ld_done);
    expect_val("mrst_reg12", 0);   observe(rd_data1);
    expect_val("mrst_reg3", 0);    observe(rd_data2);
    step();
    expect_val("mrst_no_done2", 0); observe(ld_done);
    start_load(4'd12);
    for (int i = 0; i < 4; i++) beat(32'hC100_0000 + 32'(i));
    expect_val("ld12_done", 1); observe(ld_done);
    step();

    for (int r = 0; r < 16; r++) begin
      rd_addr1 = 4'(r);
      rd_addr2 = 4'(15 - r);
      #1;
      expect_val($sformatf("final_p1_r%0d", r), model[r]);      observe(rd_data1);
      expect_val($sformatf("final_p2_r%0d", 15 - r), model[15 - r]); observe(rd_data2);
    end

    if (sb.size() != 0) chk("scoreboard_leftover", 128'(sb.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
